// File: rtl/writeback_arbiter.sv
// writeback_arbiter: round-robin arbiter driving the register-file write port, with a pending-write scoreboard
module writeback_arbiter #(
  parameter int NUM_SRC = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_SRC-1:0]    src_valid,
  output logic [NUM_SRC-1:0]    src_ready,
  input  logic [5*NUM_SRC-1:0]  src_addr,
  input  logic [32*NUM_SRC-1:0] src_data,
  input  logic                  issue_valid,
  input  logic [4:0]            issue_addr,
  output logic [31:0]           busy,
  output logic                  reg_wren,
  output logic [4:0]            write_address,
  output logic [31:0]           write_data
);
  localparam int PW = $clog2(NUM_SRC);
  logic [PW-1:0] rr_ptr, grant, rr_next;
  logic          any, xfer;
  logic [4:0]    sel_addr;
  logic [31:0]   sel_data, busy_next;
  always_comb begin
    int idx;
    idx = 0;
    any = 1'b0;
    grant = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_SRC;
      if (!any && src_valid[idx]) begin
        any = 1'b1;
        grant = PW'(idx);
        sel_addr = src_addr[idx*5 +: 5];
        sel_data = src_data[idx*32 +: 32];
      end
    end
  end
  // Ready is suppressed during reset so no handshake can complete then
  assign xfer = any && !reset;
  assign src_ready = xfer ? (NUM_SRC'(1) << grant) : '0;
  assign rr_next = (grant == PW'(NUM_SRC - 1)) ? '0 : grant + PW'(1);
  // Set is applied after clear so a same-address issue keeps the bit high
  always_comb begin
    busy_next = busy;
    if (reg_wren) busy_next[write_address] = 1'b0;
    if (issue_valid && issue_addr != 5'd0) busy_next[issue_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
      reg_wren <= 1'b0;
      write_address <= '0;
      write_data <= '0;
      busy <= '0;
    end else begin
      rr_ptr <= xfer ? rr_next : rr_ptr;
      reg_wren <= xfer && sel_addr != 5'd0;
      write_address <= xfer ? sel_addr : write_address;
      write_data <= xfer ? sel_data : write_data;
      busy <= busy_next;
    end
  end
endmodule
